// File: rtl/a23_run_ctrl_if.sv
// Handshake and status bundle between a23_run_ctrl and its host.
// The slave side is the controller, and the master side is the host that requests runs.
interface a23_run_ctrl_if #(
    parameter int CC_WIDTH = 32
);
    logic                start;
    logic                core_terminate;
    logic                core_rst;
    logic                busy;
    logic                done;
    logic                out_capture;
    logic [CC_WIDTH-1:0] cycle_count;
    logic                timeout;

    modport master (
        output start, core_terminate,
        input  core_rst, busy, done, out_capture, cycle_count, timeout
    );

    modport slave (
        input  start, core_terminate,
        output core_rst, busy, done, out_capture, cycle_count, timeout
    );
endinterface

// File: rtl/a23_run_ctrl.sv
// Run sequencer for an a23_gc_main core: reset hold, run cycle counting, one-cycle finish strobe.
// Optional run watchdog is built in when A23_RUN_WATCHDOG_EN is defined.
module a23_run_ctrl #(
    parameter int RST_HOLD_CYCLES = 3,
    parameter int CC_WIDTH        = 32,
    parameter int WDT_LIMIT       = 100000
) (
    input  logic          clk,
    input  logic          rst,
    a23_run_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [7:0]          HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);
    localparam logic [CC_WIDTH-1:0] CC_MAX    = {CC_WIDTH{1'b1}};

    if (RST_HOLD_CYCLES < 1 || RST_HOLD_CYCLES > 255 || WDT_LIMIT < 1) begin : g_param_check
        $error("a23_run_ctrl: RST_HOLD_CYCLES or WDT_LIMIT out of range");
    end

    state_t              state_r;
    state_t              state_s;
    logic [7:0]          hold_cnt_r;
    logic [CC_WIDTH-1:0] cycle_count_r;
    logic                core_rst_s;
    logic                busy_s;
    logic                done_s;
    logic                wdt_hit_s;

`ifdef A23_RUN_WATCHDOG_EN
    localparam logic [CC_WIDTH-1:0] WDT_LIMIT_C = CC_WIDTH'(WDT_LIMIT);
    logic timeout_r;

    // Watchdog fires only if the core has not terminated on the limit cycle itself
    always_comb begin
        if (state_r == ST_RUN && !bus.core_terminate && cycle_count_r >= WDT_LIMIT_C) begin
            wdt_hit_s = 1'b1;
        end else begin
            wdt_hit_s = 1'b0;
        end
    end

    // Sticky timeout flag, cleared by the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else if (state_r == ST_IDLE && bus.start) begin
            timeout_r <= 1'b0;
        end else if (wdt_hit_s) begin
            timeout_r <= 1'b1;
        end
    end

    assign bus.timeout = timeout_r;
`else
    assign wdt_hit_s   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; terminate is ignored outside RUN
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_HOLD;
                else           state_s = ST_IDLE;
            end
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) state_s = ST_RUN;
                else                         state_s = ST_HOLD;
            end
            ST_RUN: begin
                if (bus.core_terminate || wdt_hit_s) state_s = ST_FINISH;
                else                                 state_s = ST_RUN;
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Hold counter and saturating run-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r    <= 8'd0;
            cycle_count_r <= {CC_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        hold_cnt_r    <= 8'd0;
                        cycle_count_r <= {CC_WIDTH{1'b0}};
                    end
                end
                ST_HOLD: hold_cnt_r <= hold_cnt_r + 8'd1;
                ST_RUN: begin
                    if (!bus.core_terminate && !wdt_hit_s && cycle_count_r != CC_MAX) begin
                        cycle_count_r <= cycle_count_r + CC_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the registered state only
    always_comb begin
        core_rst_s = 1'b1;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE:   begin core_rst_s = 1'b1; busy_s = 1'b0; done_s = 1'b0; end
            ST_HOLD:   begin core_rst_s = 1'b1; busy_s = 1'b1; done_s = 1'b0; end
            ST_RUN:    begin core_rst_s = 1'b0; busy_s = 1'b1; done_s = 1'b0; end
            ST_FINISH: begin core_rst_s = 1'b0; busy_s = 1'b1; done_s = 1'b1; end
            default:   begin core_rst_s = 1'b1; busy_s = 1'b0; done_s = 1'b0; end
        endcase
    end

    assign bus.core_rst    = core_rst_s;
    assign bus.busy        = busy_s;
    assign bus.done        = done_s;
    assign bus.out_capture = done_s;
    assign bus.cycle_count = cycle_count_r;
endmodule

// File: tb/tb_a23_run_ctrl.sv
// Self-checking bench for a23_run_ctrl: randomized runs against a per-run timeline model.
module tb_a23_run_ctrl;
    localparam int H   = 3;
    localparam int WDT = 100;
`ifdef A23_RUN_WATCHDOG_EN
    localparam int WDT_EN = 1;
`else
    localparam int WDT_EN = 0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    a23_run_ctrl_if #(.CC_WIDTH(32)) bus_if ();
    a23_run_ctrl_if #(.CC_WIDTH(4))  sm_if ();

    a23_run_ctrl #(.RST_HOLD_CYCLES(H), .CC_WIDTH(32), .WDT_LIMIT(WDT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    a23_run_ctrl #(.RST_HOLD_CYCLES(1), .CC_WIDTH(4), .WDT_LIMIT(15)) sm_dut (
        .clk (clk),
        .rst (rst),
        .bus (sm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One run: start now, terminate raised on RUN cycle n (n beyond budget = never).
    // Timeline model: HOLD for H cycles, RUN cycles j=0..end, one FINISH cycle, then IDLE.
    task automatic run_once(input int n, input bit spam, input bit keep);
        int         end_j;
        bit         to_exp;
        logic [3:0] exp_o;
        logic [31:0] exp_cc;
        logic       exp_to;
        logic [3:0] got_o;
        to_exp = (WDT_EN != 0) && (n > WDT);
        end_j  = to_exp ? WDT : n;
        bus_if.start          = 1'b1;
        bus_if.core_terminate = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int k = 1; k <= H + end_j + 2; k++) begin
            if (k <= H) begin
                exp_o = 4'b1100; exp_cc = 32'd0; exp_to = 1'b0;
            end else if (k <= H + 1 + end_j) begin
                exp_o = 4'b0100; exp_cc = 32'(k - H - 1); exp_to = 1'b0;
            end else begin
                exp_o = 4'b0111; exp_cc = 32'(end_j); exp_to = to_exp;
            end
            got_o = {bus_if.core_rst, bus_if.busy, bus_if.done, bus_if.out_capture};
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL run_outputs k=%0d n=%0d got %b exp %b", k, n, got_o, exp_o);
            end
            checks++;
            if (bus_if.cycle_count !== exp_cc) begin
                errors++;
                $display("FAIL run_count k=%0d n=%0d got %0d exp %0d", k, n, bus_if.cycle_count, exp_cc);
            end
            checks++;
            if (bus_if.timeout !== exp_to) begin
                errors++;
                $display("FAIL run_timeout k=%0d got %b exp %b", k, bus_if.timeout, exp_to);
            end
            if (k > H && k <= H + 1 + end_j) bus_if.core_terminate = ((k - H - 1) == n);
            else                              bus_if.core_terminate = 1'($urandom_range(0, 1));
            bus_if.start = keep ? 1'b1 : (spam ? 1'($urandom_range(0, 1)) : 1'b0);
            @(negedge clk);
        end
        got_o = {bus_if.core_rst, bus_if.busy, bus_if.done, bus_if.out_capture};
        checks++;
        if (got_o !== 4'b1000 || bus_if.cycle_count !== 32'(end_j) || bus_if.timeout !== to_exp) begin
            errors++;
            $display("FAIL run_idle got o=%b cc=%0d to=%b exp o=1000 cc=%0d to=%b",
                     got_o, bus_if.cycle_count, bus_if.timeout, end_j, to_exp);
        end
        bus_if.core_terminate = 1'b0;
        bus_if.start          = keep;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.start = 1'b1; bus_if.core_terminate = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus_if.core_rst, bus_if.busy, bus_if.done, bus_if.out_capture} !== 4'b1000 ||
                bus_if.cycle_count !== 32'd0 || bus_if.timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got o=%b cc=%0d exp o=1000 cc=0", i,
                         {bus_if.core_rst, bus_if.busy, bus_if.done, bus_if.out_capture}, bus_if.cycle_count);
            end
        end
        rst = 1'b0; bus_if.start = 1'b0; bus_if.core_terminate = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus_if.core_rst, bus_if.busy, bus_if.done, bus_if.out_capture} !== 4'b1000 ||
                bus_if.cycle_count !== 32'd0 || bus_if.timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got o=%b cc=%0d exp o=1000 cc=0", i,
                         {bus_if.core_rst, bus_if.busy, bus_if.done, bus_if.out_capture}, bus_if.cycle_count);
            end
        end
    endtask

    task automatic test_basic_run();
        run_once(50, 1'b0, 1'b0);
        run_once(0, 1'b0, 1'b0);
    endtask

    task automatic test_random_runs();
        int n;
        int gap;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 40);
            run_once(n, 1'b1, 1'b0);
            gap = $urandom_range(1, 5);
            for (int g = 0; g < gap; g++) begin
                bus_if.core_terminate = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if (bus_if.busy !== 1'b0 || bus_if.core_rst !== 1'b1 || bus_if.cycle_count !== 32'(n)) begin
                    errors++;
                    $display("FAIL idle_hold got busy=%b cc=%0d exp busy=0 cc=%0d",
                             bus_if.busy, bus_if.cycle_count, n);
                end
            end
            bus_if.core_terminate = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        run_once($urandom_range(1, 20), 1'b0, 1'b1);
        run_once($urandom_range(1, 20), 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid_run();
        int dones;
        bus_if.start = 1'b1; bus_if.core_terminate = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (H + 20) @(negedge clk);
        checks++;
        if (bus_if.cycle_count !== 32'd20 || bus_if.core_rst !== 1'b0) begin
            errors++;
            $display("FAIL midrun_count got cc=%0d core_rst=%b exp cc=20 core_rst=0",
                     bus_if.cycle_count, bus_if.core_rst);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus_if.core_rst, bus_if.busy, bus_if.done, bus_if.out_capture} !== 4'b1000 ||
            bus_if.cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL midrun_abort got o=%b cc=%0d exp o=1000 cc=0",
                     {bus_if.core_rst, bus_if.busy, bus_if.done, bus_if.out_capture}, bus_if.cycle_count);
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1 || bus_if.out_capture === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midrun_nodone got %0d pulses exp 0", dones);
        end
    endtask

    task automatic test_watchdog();
`ifdef A23_RUN_WATCHDOG_EN
        run_once(100000, 1'b0, 1'b0);
        run_once(WDT, 1'b0, 1'b0);
`else
        int dones;
        bus_if.start = 1'b1; bus_if.core_terminate = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || bus_if.busy !== 1'b1 || bus_if.timeout !== 1'b0) begin
            errors++;
            $display("FAIL nowdt_run got dones=%0d busy=%b to=%b exp 0 1 0", dones, bus_if.busy, bus_if.timeout);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
    endtask

    task automatic test_saturate();
        sm_if.start = 1'b1; sm_if.core_terminate = 1'b0;
        @(negedge clk);
        sm_if.start = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if (sm_if.cycle_count !== 4'hf || sm_if.busy !== 1'b1 || sm_if.done !== 1'b0) begin
            errors++;
            $display("FAIL sat_reach got cc=%0d busy=%b done=%b exp 15 1 0", sm_if.cycle_count, sm_if.busy, sm_if.done);
        end
        @(negedge clk);
`ifdef A23_RUN_WATCHDOG_EN
        checks++;
        if (sm_if.done !== 1'b1 || sm_if.timeout !== 1'b1 || sm_if.cycle_count !== 4'hf) begin
            errors++;
            $display("FAIL sat_wdt got done=%b to=%b cc=%0d exp 1 1 15", sm_if.done, sm_if.timeout, sm_if.cycle_count);
        end
`else
        repeat (3) @(negedge clk);
        checks++;
        if (sm_if.cycle_count !== 4'hf || sm_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got cc=%0d busy=%b exp 15 1", sm_if.cycle_count, sm_if.busy);
        end
        sm_if.core_terminate = 1'b1;
        @(negedge clk);
        sm_if.core_terminate = 1'b0;
        checks++;
        if (sm_if.done !== 1'b1 || sm_if.cycle_count !== 4'hf || sm_if.timeout !== 1'b0) begin
            errors++;
            $display("FAIL sat_finish got done=%b cc=%0d to=%b exp 1 15 0", sm_if.done, sm_if.cycle_count, sm_if.timeout);
        end
`endif
        @(negedge clk);
        checks++;
        if (sm_if.busy !== 1'b0 || sm_if.core_rst !== 1'b1) begin
            errors++;
            $display("FAIL sat_idle got busy=%b core_rst=%b exp 0 1", sm_if.busy, sm_if.core_rst);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.start = 1'b0; bus_if.core_terminate = 1'b0;
        sm_if.start  = 1'b0; sm_if.core_terminate  = 1'b0;
        test_reset();
        test_basic_run();
        test_random_runs();
        test_back_to_back();
        test_rst_mid_run();
        test_watchdog();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
